// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: button edges -> registered pause/reset/adjust control and blink mask.
// All outputs registered, 1 cycle after the sampling edge; no backpressure, strobes are fire-and-forget.
module stopwatch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_2hz,
  input  logic        btn_pause,
  input  logic        btn_reset,
  input  logic        btn_adj,
  input  logic        btn_sel,
  input  logic        btn_inc,
  input  logic [15:0] cur_val,
  output logic [1:0]  mode,
  output logic        paused,
  output logic        cnt_rst,
  output logic        adj_we,
  output logic [2:0]  adj_sel,
  output logic [3:0]  adj_val,
  output logic        blink_on
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    PAUSE  = 2'b01,
    ADJUST = 2'b10
  } state_t;

  state_t state;

  logic prev_pause;
  logic prev_reset;
  logic prev_sel;
  logic prev_inc;
  logic sel_pend;

  logic rise_pause;
  logic rise_reset;
  logic rise_sel;
  logic rise_inc;

  logic [3:0] digit;
  logic [3:0] digit_max;
  logic [3:0] digit_nxt;
  logic [2:0] sel_nxt;

  assign rise_pause = btn_pause & ~prev_pause;
  assign rise_reset = btn_reset & ~prev_reset;
  assign rise_sel   = btn_sel   & ~prev_sel;
  assign rise_inc   = btn_inc   & ~prev_inc;

  assign mode = state;

  always_comb begin
    digit = cur_val[3:0];
    case (adj_sel)
      3'd0:    digit = cur_val[15:12];
      3'd1:    digit = cur_val[11:8];
      3'd2:    digit = cur_val[7:4];
      default: digit = cur_val[3:0];
    endcase
  end

  // Tens-of-seconds digit only counts to 5; out-of-range digits collapse to 0.
  assign digit_max = (adj_sel == 3'd2) ? 4'd5 : 4'd9;
  assign digit_nxt = (digit >= digit_max) ? 4'd0 : digit + 4'd1;
  assign sel_nxt   = {1'b0, adj_sel[1:0] + 2'd1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PAUSE;
      paused     <= 1'b1;
      cnt_rst    <= 1'b0;
      adj_we     <= 1'b0;
      adj_sel    <= 3'd7;
      adj_val    <= 4'd0;
      blink_on   <= 1'b1;
      sel_pend   <= 1'b0;
      prev_pause <= 1'b0;
      prev_reset <= 1'b0;
      prev_sel   <= 1'b0;
      prev_inc   <= 1'b0;
    end else begin
      prev_pause <= btn_pause;
      prev_reset <= btn_reset;
      prev_sel   <= btn_sel;
      prev_inc   <= btn_inc;
      cnt_rst    <= 1'b0;
      adj_we     <= 1'b0;

      if (rise_reset) begin
        state    <= PAUSE;
        paused   <= 1'b1;
        cnt_rst  <= 1'b1;
        adj_sel  <= 3'd7;
        blink_on <= 1'b1;
        sel_pend <= 1'b0;
      end else if (btn_adj && state != ADJUST) begin
        state    <= ADJUST;
        paused   <= 1'b1;
        adj_sel  <= 3'd0;
        blink_on <= 1'b1;
        sel_pend <= 1'b0;
      end else if (!btn_adj && state == ADJUST) begin
        state    <= PAUSE;
        paused   <= 1'b1;
        adj_sel  <= 3'd7;
        blink_on <= 1'b1;
        sel_pend <= 1'b0;
      end else if (state != ADJUST) begin
        blink_on <= 1'b1;
        if (rise_pause) begin
          state  <= (state == RUN) ? PAUSE : RUN;
          paused <= (state == RUN);
        end
      end else begin
        // A select coinciding with a write is held back one cycle so the
        // counter sees the written digit's index alongside the strobe.
        if (sel_pend) begin
          adj_sel  <= sel_nxt;
          sel_pend <= 1'b0;
        end
        if (rise_inc) begin
          adj_we  <= 1'b1;
          adj_val <= digit_nxt;
          if (rise_sel)
            sel_pend <= 1'b1;
        end else if (rise_sel) begin
          adj_sel <= sel_nxt;
        end
        if (rise_inc || rise_sel)
          blink_on <= 1'b1;
        else if (tick_2hz)
          blink_on <= ~blink_on;
      end
    end
  end

endmodule
